// File: rtl/sha3_pkg.sv
// Shared types for the keccak front end.
//   WORD_BYTES   : bytes per core input word
//   sha3_word_t  : one core input word
//   byte_num_t   : valid-byte count in a final word
//   pack_state_e : packer FSM states
//   place_byte() : ORs a byte into a word at a big-endian slot
package sha3_pkg;

  localparam int WORD_BYTES = 8;

  typedef logic [8*WORD_BYTES-1:0] sha3_word_t;
  typedef logic [2:0]              byte_num_t;

  typedef enum logic [1:0] {
    FILL,
    PUSH,
    PUSH_L,
    TAIL
  } pack_state_e;

  // Slot 0 lands in the top byte so the first message byte leads the word.
  function automatic sha3_word_t place_byte(input sha3_word_t acc,
                                            input logic [2:0] slot,
                                            input logic [7:0] b);
    sha3_word_t ext;
    ext = sha3_word_t'(b);
    return acc | (ext << (8 * (WORD_BYTES - 1 - int'(slot))));
  endfunction

endpackage

// File: rtl/sha3_msg_packer.sv
// sha3_msg_packer: packs a valid/ready byte stream into big-endian 64-bit
// words for the keccak core, ending every message with an is_last word.
//
// Ports:
//   clock, reset_n             : clock, async active-low reset
//   s_valid/s_ready/s_data/s_last : upstream byte stream
//   in, in_ready               : word and word-valid to core
//   byte_num, is_last          : valid bytes / final-word flag
//   buffer_full                : core back-pressure
//   msg_bytes, msg_done        : per-message byte count (only with
//                                SHA3_PACK_BYTE_CNT_EN defined)
//
// Build option SHA3_PACK_BYTE_CNT_EN adds the message byte counter.
import sha3_pkg::*;

module sha3_msg_packer #(
  parameter int WORD_BYTES = 8,
  parameter int CNT_W      = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [7:0]              s_data,
  input  logic                    s_last,
  output logic [8*WORD_BYTES-1:0] in,
  output logic                    in_ready,
  output byte_num_t               byte_num,
  output logic                    is_last,
  input  logic                    buffer_full
`ifdef SHA3_PACK_BYTE_CNT_EN
  ,
  output logic [CNT_W-1:0]        msg_bytes,
  output logic                    msg_done
`endif
);

  // The core word format is fixed; reject any other configuration early.
  if (WORD_BYTES != 8 || CNT_W < 1) begin : g_bad_cfg
    $error("sha3_msg_packer: WORD_BYTES must be 8 and CNT_W >= 1");
  end

  pack_state_e state;
  logic [2:0]  cnt;       // next free slot while filling
  sha3_word_t  acc;       // partial word being assembled
  sha3_word_t  acc_nxt;
  logic [3:0]  cnt_nxt;   // byte count including the incoming byte (1..8)
  logic        xfer;

  assign s_ready = (state == FILL);
  assign xfer    = in_ready && !buffer_full;
  assign acc_nxt = place_byte(acc, cnt, s_data);
  assign cnt_nxt = {1'b0, cnt} + 4'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FILL;
      cnt      <= '0;
      acc      <= '0;
      in       <= '0;
      in_ready <= 1'b0;
      byte_num <= '0;
      is_last  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (s_valid) begin
            if (s_last) begin
              // Accumulator hands off to the output register, so it is
              // already clean for the next message.
              in       <= acc_nxt;
              in_ready <= 1'b1;
              cnt      <= '0;
              acc      <= '0;
              if (cnt_nxt == 4'd8) begin
                // Full final word: the core still needs an empty is_last word.
                state    <= PUSH_L;
                is_last  <= 1'b0;
                byte_num <= '0;
              end else begin
                state    <= TAIL;
                is_last  <= 1'b1;
                byte_num <= cnt_nxt[2:0];
              end
            end else if (cnt == 3'd7) begin
              state    <= PUSH;
              in       <= acc_nxt;
              in_ready <= 1'b1;
              is_last  <= 1'b0;
              byte_num <= '0;
              cnt      <= '0;
              acc      <= '0;
            end else begin
              acc <= acc_nxt;
              cnt <= cnt_nxt[2:0];
            end
          end
        end
        PUSH: begin
          if (xfer) begin
            state    <= FILL;
            in_ready <= 1'b0;
          end
        end
        PUSH_L: begin
          // in_ready stays up: the empty final word follows immediately.
          if (xfer) begin
            state    <= TAIL;
            in       <= '0;
            is_last  <= 1'b1;
            byte_num <= '0;
          end
        end
        TAIL: begin
          if (xfer) begin
            state    <= FILL;
            in_ready <= 1'b0;
            is_last  <= 1'b0;
            byte_num <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef SHA3_PACK_BYTE_CNT_EN
  logic [CNT_W-1:0] run_cnt;  // bytes accepted so far in the current message

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt   <= '0;
      msg_bytes <= '0;
      msg_done  <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      if (state == TAIL && xfer) begin
        // No byte can be accepted in TAIL, so the count is final here.
        msg_bytes <= run_cnt;
        msg_done  <= 1'b1;
        run_cnt   <= '0;
      end else if (s_valid && s_ready && run_cnt != {CNT_W{1'b1}}) begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
